// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage state encodings and reset/NOP defaults.
// Provides a default `DATA_WIDTH of 32 when none is given.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package fetch_unit_pkg;

  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_REQ   = 3'd1,
    FETCH_WAIT  = 3'd2,
    FETCH_HOLD  = 3'd3,
    FETCH_FAULT = 3'd4
  } fetch_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;

  localparam logic [`DATA_WIDTH-1:0] RESET_PC_DEFAULT = '0;

  function automatic logic pc_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_fsm.sv
// Fetch sequencing FSM: request, wait for response, hold until commit.
// With FETCH_MISALIGN_TRAP_EN, a misaligned commit target parks the FSM in FAULT.
module fetch_unit_fsm
  import fetch_unit_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_ready,
  input  logic rsp_valid,
  input  logic commit,
`ifdef FETCH_MISALIGN_TRAP_EN
  input  logic misaligned,
  output logic fault,
`endif
  output logic req_valid,
  output logic capture,
  output logic load_pc
);

  fetch_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    capture   = 1'b0;
    load_pc   = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault     = 1'b0;
`endif
    unique case (state_q)
      FETCH_IDLE: state_d = FETCH_REQ;
      FETCH_REQ: begin
        req_valid = 1'b1;
        if (req_ready) state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (rsp_valid) begin
          capture = 1'b1;
          state_d = FETCH_HOLD;
        end
      end
      FETCH_HOLD: begin
        if (commit) begin
          load_pc = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
          state_d = misaligned ? FETCH_FAULT : FETCH_REQ;
`else
          state_d = FETCH_REQ;
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      FETCH_FAULT: fault = 1'b1;
`endif
      default: state_d = FETCH_IDLE;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one fetch at a time, holds the instruction.
// Optional misaligned-PC trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [`DATA_WIDTH-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0]            NOP_INSTR = NOP_ENCODING
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [`DATA_WIDTH-1:0] pc_next,
  input  logic                   commit,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [`DATA_WIDTH-1:0] imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [31:0]            imem_rsp_data,
  output logic                   instr_valid,
  output logic [31:0]            instr,
  output logic [`DATA_WIDTH-1:0] pc_current,
  output logic                   fetch_fault
);

  logic [`DATA_WIDTH-1:0] pc_q, pc_d, pc_load;
  logic [31:0]            instr_q, instr_d;
  logic                   instr_valid_q, instr_valid_d;
  logic                   capture, load_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault;

  // Load the raw target so the faulting PC remains visible.
  assign pc_load     = pc_next;
  assign fetch_fault = fault;
`else
  logic unused_pc_low;

  assign unused_pc_low = ^pc_next[1:0];
  assign pc_load       = {pc_next[`DATA_WIDTH-1:2], 2'b00};
  assign fetch_fault   = 1'b0;
`endif

  fetch_unit_fsm u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_ready (imem_req_ready),
    .rsp_valid (imem_rsp_valid),
    .commit    (commit),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misaligned(pc_misaligned(pc_next[1:0])),
    .fault     (fault),
`endif
    .req_valid (imem_req_valid),
    .capture   (capture),
    .load_pc   (load_pc)
  );

  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    if (capture) begin
      instr_d       = imem_rsp_data;
      instr_valid_d = 1'b1;
    end else if (load_pc) begin
      pc_d          = pc_load;
      instr_d       = NOP_INSTR;
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req_addr = pc_q;
  assign pc_current    = pc_q;
  assign instr_valid   = instr_valid_q;
  assign instr         = instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table of fetches plus reset and misalign sequences.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_fetch_unit;

  localparam int W = `DATA_WIDTH;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] pc_next = '0;
  logic         commit = 1'b0;
  logic         imem_req_valid;
  logic         imem_req_ready = 1'b0;
  logic [W-1:0] imem_req_addr;
  logic         imem_rsp_valid = 1'b0;
  logic [31:0]  imem_rsp_data = '0;
  logic         instr_valid;
  logic [31:0]  instr;
  logic [W-1:0] pc_current;
  logic         fetch_fault;

  int errors = 0;
  int checks = 0;
  logic [31:0]  exp_q[$];
  logic [W-1:0] exp_addr;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_next       (pc_next),
    .commit        (commit),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .pc_current    (pc_current),
    .fetch_fault   (fetch_fault)
  );

  typedef struct {
    logic [W-1:0] pc_next;
    logic [31:0]  data;
    int           ready_dly;
    int           rsp_dly;
    bit           noise;
    logic [W-1:0] exp_pc;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req_valid && n < 10) begin
      step();
      n++;
    end
    check("req_valid", {63'd0, imem_req_valid}, 64'd1);
    check("req_addr", 64'(imem_req_addr), 64'(exp_addr));
  endtask

  // Drive one fetch from REQ through to HOLD, with optional stalls and noise.
  task automatic fetch_to_hold(input vec_t v);
    wait_req();
    for (int i = 0; i < v.ready_dly; i++) begin
      if (v.noise) begin
        commit         = 1'b1;
        pc_next        = 32'h0BAD_0000;
        imem_rsp_valid = (i == 0);
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
      step();
      commit         = 1'b0;
      imem_rsp_valid = 1'b0;
      check("req_stable_valid", {63'd0, imem_req_valid}, 64'd1);
      check("req_stable_addr", 64'(imem_req_addr), 64'(exp_addr));
      check("req_no_instr", {63'd0, instr_valid}, 64'd0);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    exp_q.push_back(v.data);
    check("wait_req_low", {63'd0, imem_req_valid}, 64'd0);
    for (int i = 0; i < v.rsp_dly; i++) begin
      if (v.noise) begin
        commit  = 1'b1;
        pc_next = 32'h0BAD_0004;
      end
      step();
      commit = 1'b0;
      check("wait_no_instr", {63'd0, instr_valid}, 64'd0);
      check("wait_no_req", {63'd0, imem_req_valid}, 64'd0);
      check("wait_pc", 64'(pc_current), 64'(exp_addr));
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = v.data;
    step();
    imem_rsp_valid = 1'b0;
    check("hold_valid", {63'd0, instr_valid}, 64'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      check("hold_instr", {32'd0, instr}, {32'd0, exp_q.pop_front()});
    end
    if (v.noise) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hFACE_F00D;
      step();
      imem_rsp_valid = 1'b0;
      step();
      check("spurious_hold_instr", {32'd0, instr}, {32'd0, v.data});
      check("spurious_hold_valid", {63'd0, instr_valid}, 64'd1);
      check("hold_no_req", {63'd0, imem_req_valid}, 64'd0);
    end
  endtask

  task automatic do_commit(input logic [W-1:0] target);
    commit  = 1'b1;
    pc_next = target;
    step();
    commit  = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'h0000_0010, 32'h1111_1111, 0, 0, 1'b0, 32'h0000_0010};
    vecs[1] = '{32'h0000_0024, 32'h2222_2222, 5, 2, 1'b1, 32'h0000_0024};
    vecs[2] = '{32'hFFFF_FFFC, 32'h3333_3333, 1, 0, 1'b1, 32'hFFFF_FFFC};
    vecs[3] = '{32'h0000_0000, 32'h4444_4444, 2, 3, 1'b0, 32'h0000_0000};
    vecs[4] = '{32'h0000_1000, 32'h5555_5555, 0, 1, 1'b1, 32'h0000_1000};
    vecs[5] = '{32'h0000_0040, 32'h6666_6666, 0, 0, 1'b0, 32'h0000_0040};

    // Reset state
    #12;
    check("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    check("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
    check("rst_instr", {32'd0, instr}, {32'd0, NOP});
    check("rst_pc", 64'(pc_current), 64'd0);
    check("rst_fault", {63'd0, fetch_fault}, 64'd0);
    step();
    rst_n = 1'b1;
    check("idle_req_low", {63'd0, imem_req_valid}, 64'd0);
    step();
    exp_addr = '0;

    foreach (vecs[i]) begin
      fetch_to_hold(vecs[i]);
      do_commit(vecs[i].pc_next);
      check("commit_pc", 64'(pc_current), 64'(vecs[i].exp_pc));
      check("commit_instr_valid", {63'd0, instr_valid}, 64'd0);
      check("commit_instr", {32'd0, instr}, {32'd0, NOP});
      exp_addr = vecs[i].exp_pc;
    end

    // Reset while waiting for a response at PC 0x40
    wait_req();
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("pre_rst_pc", 64'(pc_current), 64'h40);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc", 64'(pc_current), 64'd0);
    check("mid_rst_req", {63'd0, imem_req_valid}, 64'd0);
    check("mid_rst_valid", {63'd0, instr_valid}, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    exp_addr = '0;
    fetch_to_hold('{32'h0, 32'h7777_7777, 0, 0, 1'b0, 32'h0});

    // Misaligned commit target
    do_commit(32'h0000_0022);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_pc", 64'(pc_current), 64'h22);
    check("mis_fault", {63'd0, fetch_fault}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      imem_req_ready = 1'b1;
      step();
      check("fault_no_req", {63'd0, imem_req_valid}, 64'd0);
      check("fault_sticky", {63'd0, fetch_fault}, 64'd1);
      check("fault_no_instr", {63'd0, instr_valid}, 64'd0);
    end
    imem_req_ready = 1'b0;
`else
    check("mis_pc", 64'(pc_current), 64'h20);
    check("mis_fault", {63'd0, fetch_fault}, 64'd0);
    exp_addr = 32'h0000_0020;
    fetch_to_hold('{32'h0, 32'h8888_8888, 1, 0, 1'b0, 32'h0});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly downstream of the next-PC logic.
- Owns the architectural PC register and issues one instruction-memory request per instruction.
- Holds the returned instruction for decode/execute until the core commits it.
- On commit, loads the core's computed next PC and begins the next fetch.
- Single outstanding request; in-order, one-instruction-at-a-time core.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013: instruction value presented while no valid instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  Rising-edge clock.
- rst_n  in  1  Asynchronous active-low reset.
- pc_next  in  `DATA_WIDTH  Next PC from the next-PC logic; sampled only on commit.
- commit  in  1  Core has finished the held instruction; advance PC.
- imem_req_valid  out  1  Fetch request valid.
- imem_req_ready  in  1  Memory accepts the request this cycle.
- imem_req_addr  out  `DATA_WIDTH  Fetch address; equals pc_current.
- imem_rsp_valid  in  1  Response data valid.
- imem_rsp_data  in  32  Fetched instruction word.
- instr_valid  out  1  instr holds a fetched, uncommitted instruction.
- instr  out  32  Held instruction, or NOP_INSTR when not valid.
- pc_current  out  `DATA_WIDTH  PC of the instruction being fetched or held.
- fetch_fault  out  1  Misaligned-PC fault (only with the optional feature; otherwise tied 0).

Behaviour:
- Reset (async assert, synchronous release):
  - State IDLE; pc_current=RESET_PC.
  - imem_req_valid=0, instr_valid=0, instr=NOP_INSTR, fetch_fault=0.
- States: IDLE, REQ, WAIT, HOLD, plus FAULT (optional feature only).
- IDLE: unconditionally goes to REQ on the first clock after reset release.
- REQ:
  - imem_req_valid=1 and imem_req_addr=pc_current; both stay stable until imem_req_ready=1.
  - On valid&&ready, go to WAIT.
  - imem_rsp_valid is ignored in REQ.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid=1: instr<=imem_rsp_data, instr_valid<=1, go to HOLD.
  - The response is therefore visible the cycle after imem_rsp_valid.
  - A response is never accepted in the same cycle as its request.
- HOLD:
  - instr and instr_valid stay stable.
  - On commit=1: pc_current<=pc_next, instr_valid<=0, instr<=NOP_INSTR, go to REQ.
  - Without commit, HOLD persists indefinitely.
- commit is ignored in IDLE, REQ and WAIT; the PC does not change.
- imem_rsp_valid outside WAIT is dropped; no state change.
- Minimum fetch-to-fetch period with zero-wait memory: 3 cycles (REQ, WAIT, HOLD+commit).
- pc_next is registered without arithmetic; full `DATA_WIDTH wrap is the producer's responsibility.
- Reset mid-operation:
  - Returns to IDLE immediately and deasserts imem_req_valid asynchronously.
  - The instruction memory shares rst_n, so no stale response survives reset.
- pc_current never changes except on commit in HOLD, or on reset.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Commit with pc_next[1:0]!=2'b00 loads the PC, then enters FAULT instead of REQ.
  - In FAULT: fetch_fault=1, imem_req_valid=0, instr_valid=0; no further fetches.
  - Exit from FAULT only via rst_n.
- Undefined:
  - pc_next[1:0] is forced to 2'b00 when loaded.
  - fetch_fault is constant 0 and the FAULT state is not built.

Decomposition:
- Shared package/header (alongside `DATA_WIDTH):
  - State encodings FETCH_IDLE/REQ/WAIT/HOLD/FAULT.
  - NOP encoding constant.
  - RESET_PC default.
- One natural sub-module: fetch_fsm (state register plus next-state/output decode).
- The PC and instruction registers stay in fetch_unit.

Test Plan:
- Reset release, imem_req_ready=1, response one cycle after accept:
  - imem_req_addr=0x0 asserted on cycle 2.
  - instr_valid=1 with the returned word on cycle 4.
  - pc_current=0x0 throughout.
- HOLD with commit=1 and pc_next=0x0000_0010:
  - Next cycle pc_current=0x10, instr_valid=0, instr=0x13.
  - The following cycle imem_req_valid=1 with addr=0x10.
- imem_req_ready low for 5 cycles in REQ:
  - imem_req_valid and addr stay stable all 5 cycles.
  - One accept only; commit pulses during REQ and WAIT leave pc_current unchanged.
- Spurious imem_rsp_valid in REQ and in HOLD:
  - instr unchanged, state unchanged.
  - The next legitimate response in WAIT is captured.
- rst_n asserted while in WAIT with pc_current=0x40:
  - Immediately pc_current=RESET_PC, imem_req_valid=0, instr_valid=0.
  - Fetch restarts from RESET_PC.
- Commit with pc_next=0x0000_0022:
  - With FETCH_MISALIGN_TRAP_EN: fetch_fault=1 and no further imem_req_valid.
  - Without it: pc_current=0x20 and the fetch proceeds at 0x20.
